// File: rtl/teclado_ctrl.sv
// Keypad capture controller: synchronises and debounces the encoder strobe, queues key
// codes in a small FIFO and arbitrates the 32-bit key register between keypad and processor.
//
// state     | meaning
// IDLE      | no key, waiting for synced strobe
// DEB_PRESS | strobe high, counting stable cycles before accepting the press
// HELD      | press accepted and pushed, waiting for release
// DEB_REL   | strobe low, counting stable cycles before accepting the release
module teclado_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [3:0]                    KEY_CODE,
    input  logic                          KEY_STROBE,
    input  logic                          CPU_WE,
    input  logic [31:0]                   CPU_DATA,
    input  logic                          CPU_RD_ACK,
    output logic [31:0]                   REG_OUT,
    output logic                          KEY_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          FIFO_FULL,
    output logic                          OVERRUN
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] FULL_LVL   = CW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DEB_RELOAD = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} stateT;

    stateT          state, stateNext;
    logic [DW-1:0]  debCnt, debCntNext;
    logic           pushReq;

    logic           strobeMeta, strobeSync;
    logic [3:0]     codeMeta, codeSync;

    logic [3:0]     fifoMem [FIFO_DEPTH];
    logic [PW-1:0]  wrPtr, rdPtr;
    logic           popDo, pushDo;
    logic [CW-1:0]  countNext;

    // debCnt is a down-counter of stable cycles still required; entry already counts one
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            debCnt <= '0;
        end else begin
            state  <= stateNext;
            debCnt <= debCntNext;
        end
    end

    always_comb begin
        stateNext  = state;
        debCntNext = debCnt;
        pushReq    = 1'b0;
        case (state)
            IDLE: begin
                if (strobeSync) begin
                    stateNext  = DEB_PRESS;
                    debCntNext = DEB_RELOAD;
                end
            end
            DEB_PRESS: begin
                if (!strobeSync) begin
                    stateNext  = IDLE;
                    debCntNext = '0;
                end else if (debCnt == DEB_LAST) begin
                    pushReq    = 1'b1;
                    stateNext  = HELD;
                    debCntNext = '0;
                end else begin
                    debCntNext = debCnt - DEB_LAST;
                end
            end
            HELD: begin
                if (!strobeSync) begin
                    stateNext  = DEB_REL;
                    debCntNext = DEB_RELOAD;
                end
            end
            DEB_REL: begin
                if (strobeSync) begin
                    stateNext  = HELD;
                    debCntNext = '0;
                end else if (debCnt == DEB_LAST) begin
                    stateNext  = IDLE;
                    debCntNext = '0;
                end else begin
                    debCntNext = debCnt - DEB_LAST;
                end
            end
            default: begin
                stateNext  = IDLE;
                debCntNext = '0;
            end
        endcase
    end

    // a pop frees a slot this cycle, so a push into a full FIFO is still taken
    always_comb begin
        popDo     = (FIFO_COUNT != '0) && !KEY_VALID && !CPU_WE;
        pushDo    = pushReq && ((FIFO_COUNT != FULL_LVL) || popDo);
        countNext = FIFO_COUNT;
        if (pushDo && !popDo) begin
            countNext = FIFO_COUNT + CW'(1);
        end else if (popDo && !pushDo) begin
            countNext = FIFO_COUNT - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            strobeMeta <= 1'b0;
            strobeSync <= 1'b0;
            codeMeta   <= '0;
            codeSync   <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            FIFO_COUNT <= '0;
            FIFO_FULL  <= 1'b0;
            REG_OUT    <= '0;
            KEY_VALID  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            strobeMeta <= KEY_STROBE;
            strobeSync <= strobeMeta;
            codeMeta   <= KEY_CODE;
            codeSync   <= codeMeta;

            if (pushDo) begin
                fifoMem[wrPtr] <= codeSync;
                wrPtr          <= wrPtr + PW'(1);
            end
            if (popDo) begin
                rdPtr <= rdPtr + PW'(1);
            end
            FIFO_COUNT <= countNext;
            FIFO_FULL  <= (countNext == FULL_LVL);

            if (CPU_WE) begin
                REG_OUT   <= CPU_DATA;
                KEY_VALID <= 1'b0;
            end else if (popDo) begin
                REG_OUT   <= {28'b0, fifoMem[rdPtr]};
                KEY_VALID <= 1'b1;
            end else if (CPU_RD_ACK) begin
                KEY_VALID <= 1'b0;
            end

            // a drop in the same cycle as a CPU write still leaves the flag set
            if (pushReq && !pushDo) begin
                OVERRUN <= 1'b1;
            end else if (CPU_WE) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_teclado_ctrl.sv
// Directed bench for teclado_ctrl: debounce timing, FIFO fill/overrun, read-ack drain,
// CPU write priority and mid-press reset.
module tb_teclado_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  KEY_CODE;
    logic        KEY_STROBE;
    logic        CPU_WE;
    logic [31:0] CPU_DATA;
    logic        CPU_RD_ACK;
    logic [31:0] REG_OUT;
    logic        KEY_VALID;
    logic [2:0]  FIFO_COUNT;
    logic        FIFO_FULL;
    logic        OVERRUN;

    int total = 0;
    int bad   = 0;
    int lat;

    teclado_ctrl #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .KEY_CODE   (KEY_CODE),
        .KEY_STROBE (KEY_STROBE),
        .CPU_WE     (CPU_WE),
        .CPU_DATA   (CPU_DATA),
        .CPU_RD_ACK (CPU_RD_ACK),
        .REG_OUT    (REG_OUT),
        .KEY_VALID  (KEY_VALID),
        .FIFO_COUNT (FIFO_COUNT),
        .FIFO_FULL  (FIFO_FULL),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkOutputsZero(input string tag);
        chk({tag, "_reg"},   REG_OUT, 32'h0);
        chk({tag, "_valid"}, 32'(KEY_VALID), 32'h0);
        chk({tag, "_count"}, 32'(FIFO_COUNT), 32'h0);
        chk({tag, "_full"},  32'(FIFO_FULL), 32'h0);
        chk({tag, "_ovr"},   32'(OVERRUN), 32'h0);
    endtask

    task automatic pressKey(input logic [3:0] code, input int hold);
        KEY_CODE   = code;
        KEY_STROBE = 1'b1;
        tick(hold);
        KEY_STROBE = 1'b0;
        tick(25);
    endtask

    task automatic ackPulse();
        CPU_RD_ACK = 1'b1;
        tick(1);
        CPU_RD_ACK = 1'b0;
        tick(1);
    endtask

    // cycles until KEY_VALID first reads high; 0 if it never does within the budget
    task automatic measureValid(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (KEY_VALID === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        RESET      = 1'b1;
        KEY_CODE   = 4'h0;
        KEY_STROBE = 1'b0;
        CPU_WE     = 1'b0;
        CPU_DATA   = 32'h0;
        CPU_RD_ACK = 1'b0;
        tick(2);
        chkOutputsZero("reset");
        RESET = 1'b0;
        tick(2);

        // single clean press: 2 sync + 16 debounce + 1 pop
        KEY_CODE   = 4'h7;
        KEY_STROBE = 1'b1;
        measureValid(lat);
        chk("t1_latency", 32'(lat >= 18 && lat <= 20), 32'h1);
        tick(20);
        KEY_STROBE = 1'b0;
        tick(25);
        chk("t1_reg",   REG_OUT, 32'h7);
        chk("t1_valid", 32'(KEY_VALID), 32'h1);
        chk("t1_count", 32'(FIFO_COUNT), 32'h0);
        ackPulse();
        chk("t1_ack_valid", 32'(KEY_VALID), 32'h0);
        chk("t1_ack_hold",  REG_OUT, 32'h7);

        // short glitch, then a held key with a release bounce
        pressKey(4'h3, 10);
        chk("t2_glitch_valid", 32'(KEY_VALID), 32'h0);
        chk("t2_glitch_count", 32'(FIFO_COUNT), 32'h0);
        KEY_CODE   = 4'h9;
        KEY_STROBE = 1'b1;
        tick(30);
        KEY_STROBE = 1'b0;
        tick(5);
        KEY_STROBE = 1'b1;
        tick(20);
        KEY_STROBE = 1'b0;
        tick(25);
        chk("t2_reg",   REG_OUT, 32'h9);
        chk("t2_valid", 32'(KEY_VALID), 32'h1);
        chk("t2_count", 32'(FIFO_COUNT), 32'h0);
        ackPulse();
        chk("t2_one_key_valid", 32'(KEY_VALID), 32'h0);
        chk("t2_one_key_count", 32'(FIFO_COUNT), 32'h0);

        // fill the FIFO, then overrun
        for (int k = 1; k <= 5; k++) pressKey(4'(k), 25);
        chk("t3_reg",   REG_OUT, 32'h1);
        chk("t3_valid", 32'(KEY_VALID), 32'h1);
        chk("t3_count", 32'(FIFO_COUNT), 32'h4);
        chk("t3_full",  32'(FIFO_FULL), 32'h1);
        chk("t3_ovr0",  32'(OVERRUN), 32'h0);
        pressKey(4'h6, 25);
        chk("t3_ovr1",      32'(OVERRUN), 32'h1);
        chk("t3_ovr_count", 32'(FIFO_COUNT), 32'h4);
        chk("t3_ovr_reg",   REG_OUT, 32'h1);

        // drain with read acks; dropped code 6 must never appear
        for (int k = 2; k <= 5; k++) begin
            ackPulse();
            chk($sformatf("t4_reg_%0d", k),   REG_OUT, 32'(k));
            chk($sformatf("t4_count_%0d", k), 32'(FIFO_COUNT), 32'(5 - k));
            chk($sformatf("t4_full_%0d", k),  32'(FIFO_FULL), 32'h0);
            chk($sformatf("t4_valid_%0d", k), 32'(KEY_VALID), 32'h1);
        end
        chk("t4_ovr_sticky", 32'(OVERRUN), 32'h1);
        ackPulse();
        chk("t4_empty_valid", 32'(KEY_VALID), 32'h0);
        chk("t4_empty_reg",   REG_OUT, 32'h5);

        // CPU write collides with a due pop
        pressKey(4'hA, 25);
        pressKey(4'hB, 25);
        chk("t5_pre_reg",   REG_OUT, 32'hA);
        chk("t5_pre_count", 32'(FIFO_COUNT), 32'h1);
        CPU_RD_ACK = 1'b1;
        tick(1);
        CPU_RD_ACK = 1'b0;
        CPU_WE     = 1'b1;
        CPU_DATA   = 32'hDEADBEEF;
        tick(1);
        CPU_WE = 1'b0;
        chk("t5_we_reg",   REG_OUT, 32'hDEADBEEF);
        chk("t5_we_valid", 32'(KEY_VALID), 32'h0);
        chk("t5_we_count", 32'(FIFO_COUNT), 32'h1);
        chk("t5_we_ovr",   32'(OVERRUN), 32'h0);
        tick(1);
        chk("t5_pop_reg",   REG_OUT, 32'hB);
        chk("t5_pop_valid", 32'(KEY_VALID), 32'h1);
        chk("t5_pop_count", 32'(FIFO_COUNT), 32'h0);

        // reset during DEB_PRESS with two keys queued
        pressKey(4'hC, 25);
        pressKey(4'hD, 25);
        KEY_CODE   = 4'hE;
        KEY_STROBE = 1'b1;
        tick(10);
        chk("t6_pre_count", 32'(FIFO_COUNT), 32'h2);
        chk("t6_pre_reg",   REG_OUT, 32'hB);
        RESET = 1'b1;
        tick(1);
        chkOutputsZero("t6_reset");
        RESET = 1'b0;
        measureValid(lat);
        chk("t6_latency", 32'(lat >= 18 && lat <= 20), 32'h1);
        chk("t6_reg",     REG_OUT, 32'hE);
        chk("t6_count",   32'(FIFO_COUNT), 32'h0);
        KEY_STROBE = 1'b0;
        tick(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
